// File: rtl/fir_chroma_scheduler.sv
// Frame sequencer for the chroma FIR upsampler. It issues U/V SRAM word reads and drives the
// FIR load/shift strobes in a 6-cycle period, giving one odd U'/V' pair per period.
module fir_chroma_scheduler #(
   parameter logic [17:0] U_BASE_ADDR  = 18'd38400,
   parameter logic [17:0] V_BASE_ADDR  = 18'd57600,
   parameter int          WIDTH_UV     = 160,
   parameter int          ROWS         = 240,
   parameter int          SRAM_LATENCY = 2
) (
   input  logic        CLOCK_50_I,
   input  logic        resetn,
   input  logic        start,
   input  logic        out_ready,
   output logic [17:0] SRAM_address,
   output logic        SRAM_read_req,
   output logic        read_U_0,
   output logic        read_V_0,
   output logic        enable_U,
   output logic        enable_V,
   output logic        line_start,
   output logic        line_end,
   output logic        cycle,
   output logic        out_valid,
   output logic        busy,
   output logic        done
);

   localparam int WORDS = WIDTH_UV / 2;
   localparam int PW    = $clog2(WIDTH_UV);
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int WW    = $clog2(WORDS + 1);
   // Reads are placed so data lands exactly on the consuming shift phase (ph3 for V, ph0 for U).
   localparam int V_RD_PH = 3 - SRAM_LATENCY;
   localparam int U_RD_PH = 6 - SRAM_LATENCY;

   typedef enum logic [3:0] {
      S_IDLE, S_LI0, S_LI1, S_LI2, S_LI3, S_LI4, S_LI5, S_COMMON, S_STALL, S_ROW_END
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    phase_q, phase_d;
   logic [PW-1:0] period_q, period_d;
   logic [RW-1:0] row_q, row_d;
   logic [WW-1:0] u_word_q, u_word_d, v_word_q, v_word_d;
   logic [17:0]   u_addr_q, u_addr_d, v_addr_q, v_addr_d;
   logic          u_rd, v_rd, in_tail, last_row;

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         period_q <= '0;
         row_q    <= '0;
         u_word_q <= '0;
         v_word_q <= '0;
         u_addr_q <= '0;
         v_addr_q <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         period_q <= period_d;
         row_q    <= row_d;
         u_word_q <= u_word_d;
         v_word_q <= v_word_d;
         u_addr_q <= u_addr_d;
         v_addr_q <= v_addr_d;
      end
   end

   assign in_tail  = (period_q >= PW'(WIDTH_UV - 4));
   assign last_row = (row_q == RW'(ROWS - 1));

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      period_d   = period_q;
      row_d      = row_q;
      u_word_d   = u_word_q;
      v_word_d   = v_word_q;
      u_addr_d   = u_addr_q;
      v_addr_d   = v_addr_q;
      u_rd       = 1'b0;
      v_rd       = 1'b0;
      read_U_0   = 1'b0;
      read_V_0   = 1'b0;
      enable_U   = 1'b0;
      enable_V   = 1'b0;
      line_start = 1'b0;
      line_end   = 1'b0;
      cycle      = 1'b0;
      out_valid  = 1'b0;
      done       = 1'b0;
      busy       = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_LI0;
               u_addr_d = U_BASE_ADDR;
               v_addr_d = V_BASE_ADDR;
               row_d    = '0;
               u_word_d = '0;
               v_word_d = '0;
            end
         end
         S_LI0: begin line_start = 1'b1; u_rd = 1'b1; state_d = S_LI1; end
         S_LI1: begin line_start = 1'b1; v_rd = 1'b1; state_d = S_LI2; end
         S_LI2: begin line_start = 1'b1; u_rd = 1'b1; read_U_0 = 1'b1; state_d = S_LI3; end
         S_LI3: begin line_start = 1'b1; v_rd = 1'b1; read_V_0 = 1'b1; state_d = S_LI4; end
         S_LI4: begin line_start = 1'b1; u_rd = 1'b1; enable_U = 1'b1; state_d = S_LI5; end
         S_LI5: begin
            line_start = 1'b1;
            enable_V   = 1'b1;
            state_d    = S_COMMON;
            phase_d    = '0;
            period_d   = '0;
         end
         S_COMMON: begin
            cycle     = period_q[0];
            line_end  = in_tail;
            enable_U  = (phase_q == 3'd0);
            enable_V  = (phase_q == 3'd3);
            out_valid = (phase_q == 3'd5);
            v_rd = (phase_q == 3'(V_RD_PH)) && !period_q[0] && (v_word_q < WW'(WORDS)) && !in_tail;
            u_rd = (phase_q == 3'(U_RD_PH)) &&  period_q[0] && (u_word_q < WW'(WORDS)) && !in_tail;
            if (phase_q == 3'd3 && !out_ready) begin
               state_d = S_STALL;
            end else if (phase_q == 3'd5) begin
               phase_d = '0;
               if (period_q == PW'(WIDTH_UV - 1)) begin
                  period_d = '0;
                  state_d  = S_ROW_END;
               end else begin
                  period_d = period_q + 1'b1;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         S_STALL: begin
            // Position flags stay valid; every strobe is held off until downstream drains.
            cycle    = period_q[0];
            line_end = in_tail;
            if (out_ready) begin
               state_d = S_COMMON;
               phase_d = 3'd4;
            end
         end
         S_ROW_END: begin
            u_word_d = '0;
            v_word_d = '0;
            if (last_row) begin
               done    = 1'b1;
               busy    = 1'b0;
               row_d   = '0;
               state_d = S_IDLE;
            end else begin
               row_d   = row_q + 1'b1;
               state_d = S_LI0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (u_rd) begin
         u_addr_d = u_addr_q + 18'd1;
         u_word_d = u_word_q + 1'b1;
      end
      if (v_rd) begin
         v_addr_d = v_addr_q + 18'd1;
         v_word_d = v_word_q + 1'b1;
      end
      SRAM_read_req = u_rd | v_rd;
      SRAM_address  = u_rd ? u_addr_q : (v_rd ? v_addr_q : 18'd0);
   end

endmodule

// File: tb/tb_fir_chroma_scheduler.sv
// Directed bench for fir_chroma_scheduler: lead-in sequence, row totals, frame completion,
// a 10-cycle stall, mid-frame reset and ignored start pulses.
module tb_fir_chroma_scheduler;

   localparam int ROWS   = 5;
   localparam int ROWLEN = 967;
   localparam int U_B    = 38400;
   localparam int V_B    = 57600;

   logic        clk = 1'b0;
   logic        rst_n, start, out_ready;
   logic [17:0] SRAM_address;
   logic        SRAM_read_req, read_U_0, read_V_0, enable_U, enable_V;
   logic        line_start, line_end, cycle, out_valid, busy, done;

   fir_chroma_scheduler #(.ROWS(ROWS)) dut (
      .CLOCK_50_I(clk), .resetn(rst_n), .start(start), .out_ready(out_ready),
      .SRAM_address(SRAM_address), .SRAM_read_req(SRAM_read_req),
      .read_U_0(read_U_0), .read_V_0(read_V_0), .enable_U(enable_U), .enable_V(enable_V),
      .line_start(line_start), .line_end(line_end), .cycle(cycle),
      .out_valid(out_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int ncmp = 0, nerr = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Passive event counters sampled on the falling edge.
   int u_rd_n = 0, v_rd_n = 0, ov_n = 0, le_n = 0, done_n = 0;
   int last_u = -1, last_v = -1, gap_err = 0, ovl_err = 0;
   always @(negedge clk) begin
      if (SRAM_read_req) begin
         if (int'(SRAM_address) >= V_B) begin
            if (last_v >= 0 && int'(SRAM_address) != last_v + 1 && int'(SRAM_address) != V_B) gap_err++;
            last_v = int'(SRAM_address);
            v_rd_n++;
         end else begin
            if (last_u >= 0 && int'(SRAM_address) != last_u + 1 && int'(SRAM_address) != U_B) gap_err++;
            last_u = int'(SRAM_address);
            u_rd_n++;
         end
      end
      if (enable_U && enable_V) ovl_err++;
      ov_n   += int'(out_valid);
      le_n   += int'(line_end);
      done_n += int'(done);
   end

   function automatic logic [5:0] strobes();
      return {SRAM_read_req, read_U_0, read_V_0, enable_U, enable_V, out_valid};
   endfunction

   initial begin
      int exp_a [6] = '{38400, 57600, 38401, 57601, 38402, 0};
      logic [4:0] exp_s [6] = '{5'b00001, 5'b00001, 5'b10001, 5'b01001, 5'b00101, 5'b00011};
      int s_u, s_v, s_ov, s_le;

      rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
      #22;
      chk("rst_addr", 32'(SRAM_address), 0);
      chk("rst_strobes", 32'(strobes()), 0);
      chk("rst_flags", 32'({line_start, line_end, cycle, busy, done}), 0);
      @(negedge clk); rst_n = 1'b1;
      tick(); tick();
      chk("idle_busy", 32'(busy), 0);

      // Frame 1: lead-in, row 0 totals, frame completion; start re-pulsed while busy.
      start = 1'b1; cyc = 0;
      tick(); start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("li%0d_addr", i), 32'(SRAM_address), 32'(exp_a[i]));
         chk($sformatf("li%0d_req", i), 32'(SRAM_read_req), (i < 5) ? 32'd1 : 32'd0);
         chk($sformatf("li%0d_strb", i), 32'({read_U_0, read_V_0, enable_U, enable_V, line_start}),
             32'(exp_s[i]));
         if (i < 5) tick();
      end
      tick();
      chk("p0ph0_strb", 32'({enable_U, enable_V, line_start, cycle}), 32'b1000);
      tick();
      chk("p0ph1_vaddr", 32'(SRAM_address), 57602);
      chk("p0ph1_req", 32'(SRAM_read_req), 1);
      while (cyc < 100) tick();
      start = 1'b1; tick(); start = 1'b0;
      while (cyc < ROWLEN) tick();
      chk("row0_end_flags", 32'({line_start, busy, done}), 32'b010);
      chk("row0_u_reads", 32'(u_rd_n), 80);
      chk("row0_v_reads", 32'(v_rd_n), 80);
      chk("row0_last_u", 32'(last_u), 38479);
      chk("row0_last_v", 32'(last_v), 57679);
      chk("row0_out_valid", 32'(ov_n), 160);
      chk("row0_line_end", 32'(le_n), 24);
      tick();
      chk("row1_li0_flag", 32'(line_start), 1);
      chk("row1_li0_addr", 32'(SRAM_address), 38480);
      while (!done && cyc < 6000) tick();
      chk("done_cycle", 32'(cyc), 32'(ROWS * ROWLEN));
      chk("done_busy", 32'({done, busy}), 32'b10);
      tick();
      chk("post_done", 32'({done, busy, SRAM_read_req}), 0);
      chk("done_count", 32'(done_n), 1);
      chk("frame_last_u", 32'(last_u), 32'(U_B + ROWS * 80 - 1));
      chk("frame_last_v", 32'(last_v), 32'(V_B + ROWS * 80 - 1));

      // Frame 2: out_ready low for 10 cycles starting at ph3 of period 7.
      s_u = u_rd_n; s_v = v_rd_n; s_ov = ov_n; s_le = le_n;
      tick();
      start = 1'b1; cyc = 0;
      tick(); start = 1'b0;
      chk("f2_li0_addr", 32'(SRAM_address), 38400);
      while (cyc < 52) tick();
      chk("p7ph3_strb", 32'({enable_V, cycle}), 32'b11);
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (cyc == 62) out_ready = 1'b1;
         chk($sformatf("stall%0d_strb", k), 32'(strobes()), 0);
      end
      tick();
      chk("p7ph4_uaddr", 32'(SRAM_address), 38406);
      chk("p7ph4_req", 32'(SRAM_read_req), 1);
      tick();
      chk("p7ph5_valid", 32'(out_valid), 1);
      while (cyc < ROWLEN + 10) tick();
      chk("stall_row_end", 32'({line_start, busy, done}), 32'b010);
      chk("stall_row_u", 32'(u_rd_n - s_u), 80);
      chk("stall_row_v", 32'(v_rd_n - s_v), 80);
      chk("stall_row_ov", 32'(ov_n - s_ov), 160);
      chk("stall_row_le", 32'(le_n - s_le), 24);
      tick();
      chk("stall_row1_addr", 32'(SRAM_address), 38480);

      // Reset at ph0 of period 50 in row 3 of the stalled frame.
      while (cyc < 1 + 3 * ROWLEN + 10 + 6 + 300) tick();
      chk("r3p50_enU", 32'({enable_U, line_end, busy}), 32'b101);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_addr", 32'(SRAM_address), 0);
      chk("mid_rst_outs", 32'({strobes(), line_start, line_end, cycle, busy, done}), 0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      tick(); tick();
      chk("post_rst_idle", 32'({busy, SRAM_read_req}), 0);
      start = 1'b1; cyc = 0;
      tick(); start = 1'b0;
      chk("restart_u", 32'(SRAM_address), 38400);
      tick();
      chk("restart_v", 32'(SRAM_address), 57600);
      chk("addr_gaps", 32'(gap_err), 0);
      chk("enable_overlap", 32'(ovl_err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
